// File: rtl/serializer_feeder.sv
// serializer_feeder: byte FIFO that feeds a start/reset/done serializer one byte at a time.
// Optional macro SER_FEEDER_TIMEOUT_EN adds a 32-cycle SEND watchdog driving timeout_err.
module serializer_feeder #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             ser_data,
    output logic                   ser_start,
    output logic                   ser_reset,
    input  logic                   ser_done,
    output logic                   busy,
    output logic [15:0]            bytes_sent,
    output logic                   timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [3:0]    GAP_LOAD   = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
    logic [7:0]    ser_data_q, ser_data_d;
    logic          ser_start_q, ser_start_d, ser_reset_q, ser_reset_d;
    logic          busy_q, busy_d;
    logic [15:0]   bytes_sent_q, bytes_sent_d;
    logic [3:0]    gap_q, gap_d;
    logic          wr_accept, pop, sent_ok;
`ifdef SER_FEEDER_TIMEOUT_EN
    logic [5:0]    wd_q, wd_d;
    logic          timeout_q, timeout_d, wd_expire;
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        sent_ok = 1'b0;
`ifdef SER_FEEDER_TIMEOUT_EN
        wd_expire = 1'b0;
`endif
        case (state_q)
            IDLE: if (!empty_q) state_d = LOAD;
            LOAD: state_d = SEND;
            SEND: begin
                if (ser_done) begin
                    sent_ok = 1'b1;
                    state_d = GAP;
                end
`ifdef SER_FEEDER_TIMEOUT_EN
                else if (wd_q == 6'd31) begin
                    wd_expire = 1'b1;
                    state_d   = GAP;
                end
`endif
            end
            GAP: begin
                if (gap_q == 4'd0) state_d = empty_q ? IDLE : LOAD;
                else gap_d = gap_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        // gap_q counts the remaining GAP cycles after the current one
        if (state_d == GAP && state_q != GAP) gap_d = GAP_LOAD;
    end

    always_comb begin
        pop          = (state_d == LOAD);
        wr_accept    = wr_en && !full_q;
        wr_ptr_d     = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d      = level_q + LW'(wr_accept) - LW'(pop);
        full_d       = (level_d == FULL_LEVEL);
        empty_d      = (level_d == '0);
        overflow_d   = overflow_q | (wr_en & full_q);
        ser_data_d   = pop ? mem_q[rd_ptr_q] : ser_data_q;
        ser_start_d  = (state_d != IDLE);
        ser_reset_d  = (state_d != SEND);
        busy_d       = (state_d != IDLE);
        bytes_sent_d = sent_ok ? bytes_sent_q + 16'd1 : bytes_sent_q;
    end

`ifdef SER_FEEDER_TIMEOUT_EN
    always_comb begin
        wd_d      = (state_q == SEND && state_d == SEND) ? wd_q + 6'd1 : 6'd0;
        timeout_d = timeout_q | wd_expire;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            overflow_q   <= 1'b0;
            ser_data_q   <= 8'h00;
            ser_start_q  <= 1'b0;
            ser_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            bytes_sent_q <= 16'h0000;
            gap_q        <= 4'd0;
`ifdef SER_FEEDER_TIMEOUT_EN
            wd_q         <= 6'd0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            overflow_q   <= overflow_d;
            ser_data_q   <= ser_data_d;
            ser_start_q  <= ser_start_d;
            ser_reset_q  <= ser_reset_d;
            busy_q       <= busy_d;
            bytes_sent_q <= bytes_sent_d;
            gap_q        <= gap_d;
`ifdef SER_FEEDER_TIMEOUT_EN
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    // Storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign ser_data   = ser_data_q;
    assign ser_start  = ser_start_q;
    assign ser_reset  = ser_reset_q;
    assign busy       = busy_q;
    assign bytes_sent = bytes_sent_q;
`ifdef SER_FEEDER_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_serializer_feeder.sv
// Bench for serializer_feeder: directed vector table, hand-written corner sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_serializer_feeder;
    localparam int DEPTH      = 8;
    localparam int GAP_CYCLES = 2;
    localparam int S_IDLE = 0, S_LOAD = 1, S_SEND = 2, S_GAP = 3;

    logic        clk = 1'b0;
    logic        reset, wr_en, ser_done;
    logic [7:0]  wr_data;
    logic        full, empty, overflow, ser_start, ser_reset, busy, timeout_err;
    logic [3:0]  level;
    logic [7:0]  ser_data;
    logic [15:0] bytes_sent;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0]  m_q[$];
    int          m_st, m_gap, m_wd;
    logic [7:0]  m_data;
    logic [15:0] m_sent;
    logic        m_ovf, m_to;
    logic [7:0]  cap[$];

    typedef struct packed {
        logic rst_n; logic en; logic [7:0] d; logic done;
        logic [3:0] lvl; logic emp; logic full; logic bsy; logic st; logic sr;
        logic [7:0] dat; logic [15:0] sent; logic ovf;
    } vec_t;
    vec_t vt [9];

    serializer_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .ser_data(ser_data), .ser_start(ser_start), .ser_reset(ser_reset),
        .ser_done(ser_done), .busy(busy), .bytes_sent(bytes_sent),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_st = S_IDLE; m_gap = 0; m_wd = 0;
        m_data = 8'h00; m_sent = 16'h0000; m_ovf = 1'b0; m_to = 1'b0;
    endtask

    task automatic model_update(input logic rst_n, input logic en, input logic [7:0] d,
                                input logic done);
        bit was_full, was_empty;
        int nxt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        nxt = m_st;
        case (m_st)
            S_IDLE: if (!was_empty) nxt = S_LOAD;
            S_LOAD: begin nxt = S_SEND; m_wd = 0; end
            S_SEND: begin
                if (done) begin
                    m_sent = m_sent + 16'd1; nxt = S_GAP; m_gap = GAP_CYCLES;
                end else begin
                    m_wd++;
`ifdef SER_FEEDER_TIMEOUT_EN
                    if (m_wd == 32) begin m_to = 1'b1; nxt = S_GAP; m_gap = GAP_CYCLES; end
`endif
                end
            end
            default: begin
                m_gap--;
                if (m_gap == 0) nxt = was_empty ? S_IDLE : S_LOAD;
            end
        endcase
        if (nxt == S_LOAD) m_data = m_q.pop_front();
        if (en && !was_full) m_q.push_back(d);
        else if (en) m_ovf = 1'b1;
        m_st = nxt;
    endtask

    function automatic logic [34:0] dut_vec();
        return {level, full, empty, overflow, ser_data, ser_start, ser_reset, busy,
                bytes_sent, timeout_err};
    endfunction

    function automatic logic [34:0] model_vec();
        logic [3:0] lv;
        logic f, e, st, sr;
        lv = 4'(m_q.size());
        f  = (m_q.size() == DEPTH);
        e  = (m_q.size() == 0);
        st = (m_st != S_IDLE);
        sr = (m_st != S_SEND);
        return {lv, f, e, m_ovf, m_data, st, sr, st, m_sent, m_to};
    endfunction

    task automatic step(input logic rst_n, input logic en, input logic [7:0] d,
                        input logic done, input string tag);
        reset = rst_n; wr_en = en; wr_data = d; ser_done = done;
        @(posedge clk);
        model_update(rst_n, en, d, done);
        #1;
        check(tag, 64'(dut_vec()), 64'(model_vec()));
        @(negedge clk);
    endtask

    // Acts as the serializer: answers done in the first SEND cycle and records the byte.
    task automatic drain(input int budget);
        int  i;
        logic dn;
        i = 0;
        while ((busy || !empty) && i < budget) begin
            dn = ser_start && !ser_reset;
            if (dn) cap.push_back(ser_data);
            step(1'b1, 1'b0, 8'h00, dn, "drain");
            i++;
        end
        if (busy || !empty) begin
            n_tests++; n_fail++;
            $display("FAIL drain: busy=%0b empty=%0b after %0d cycles, required idle and empty",
                     busy, empty, budget);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ser_done = 1'b0;
        model_reset();

        // single byte 0x2D through IDLE/LOAD/SEND/GAP; done outside SEND is ignored
        vt[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 8'h2D, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2D, 16'd0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h2D, 16'd0, 1'b0};
        vt[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h2D, 16'd0, 1'b0};
        vt[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2D, 16'd1, 1'b0};
        vt[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2D, 16'd1, 1'b0};
        vt[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2D, 16'd1, 1'b0};
        vt[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2D, 16'd1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            step(vt[i].rst_n, vt[i].en, vt[i].d, vt[i].done, "vec_model");
            check($sformatf("vec%0d", i),
                  64'({level, empty, full, busy, ser_start, ser_reset, ser_data, bytes_sent, overflow}),
                  64'({vt[i].lvl, vt[i].emp, vt[i].full, vt[i].bsy, vt[i].st, vt[i].sr,
                       vt[i].dat, vt[i].sent, vt[i].ovf}));
        end

        // back-to-back burst: the first byte is popped at once, so nine writes fill it
        step(1'b0, 1'b0, 8'h00, 1'b0, "burst_rst");
        for (int k = 1; k <= 9; k++) step(1'b1, 1'b1, 8'(k), 1'b0, "burst_wr");
        check("burst_full", 64'(full), 64'd1);
        check("burst_level", 64'(level), 64'd8);
        step(1'b1, 1'b1, 8'hEE, 1'b0, "burst_ovf_wr");
        check("burst_overflow", 64'(overflow), 64'd1);
        check("burst_level_kept", 64'(level), 64'd8);
        cap.delete();
        drain(200);
        check("burst_count", 64'(cap.size()), 64'd9);
        for (int i = 0; i < cap.size(); i++)
            check($sformatf("burst_order%0d", i), 64'(cap[i]), 64'(i + 1));
        check("burst_sent", 64'(bytes_sent), 64'd9);
        check("burst_overflow_sticky", 64'(overflow), 64'd1);

        // bytes_sent wrap: preload the counter to 0xFFFF while idle, then send one byte
        force dut.bytes_sent_d = 16'hFFFF;
        m_sent = 16'hFFFF;
        step(1'b1, 1'b0, 8'h00, 1'b0, "wrap_preload");
        release dut.bytes_sent_d;
        check("wrap_at_max", 64'(bytes_sent), 64'hFFFF);
        step(1'b1, 1'b1, 8'h77, 1'b0, "wrap_wr");
        cap.delete();
        drain(50);
        check("wrap_to_zero", 64'(bytes_sent), 64'h0);
        check("wrap_byte", 64'(cap.size() > 0 ? cap[0] : 8'h00), 64'h77);

        // simultaneous write and pop at level 3, then reset in SEND of 0xA5
        step(1'b0, 1'b0, 8'h00, 1'b0, "wp_rst");
        step(1'b1, 1'b1, 8'h11, 1'b0, "wp_w11");
        step(1'b1, 1'b1, 8'hA5, 1'b0, "wp_wA5");
        step(1'b1, 1'b1, 8'h22, 1'b0, "wp_w22");
        step(1'b1, 1'b1, 8'h33, 1'b0, "wp_w33");
        check("wp_level_before", 64'(level), 64'd3);
        step(1'b1, 1'b0, 8'h00, 1'b1, "wp_done");
        step(1'b1, 1'b0, 8'h00, 1'b0, "wp_gap");
        step(1'b1, 1'b1, 8'h44, 1'b0, "wp_pop_wr");
        check("wp_level_same", 64'(level), 64'd3);
        check("wp_loaded", 64'(ser_data), 64'hA5);
        step(1'b1, 1'b0, 8'h00, 1'b0, "rs_send");
        check("rs_in_send", 64'({ser_start, ser_reset, ser_data}), 64'({1'b1, 1'b0, 8'hA5}));
        step(1'b0, 1'b0, 8'h00, 1'b1, "rs_reset");
        check("rs_values",
              64'({ser_start, ser_reset, ser_data, busy, full, empty, level, overflow, bytes_sent, timeout_err}),
              64'({1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0}));
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 1'b1, "rs_after");
        check("rs_nothing_sent", 64'({bytes_sent, busy, empty}), 64'({16'h0000, 1'b0, 1'b1}));

        // SEND with ser_done held low
        step(1'b0, 1'b0, 8'h00, 1'b0, "wd_rst");
        step(1'b1, 1'b1, 8'h5A, 1'b0, "wd_w5A");
        step(1'b1, 1'b1, 8'h3C, 1'b0, "wd_w3C");
        step(1'b1, 1'b0, 8'h00, 1'b0, "wd_enter");
`ifdef SER_FEEDER_TIMEOUT_EN
        n = 0;
        while (!ser_reset && n < 40) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, "wd_send");
            n++;
        end
        check("wd_cycles", 64'(n), 64'd32);
        check("wd_flag", 64'(timeout_err), 64'd1);
        check("wd_not_counted", 64'(bytes_sent), 64'd0);
        step(1'b1, 1'b0, 8'h00, 1'b0, "wd_gap1");
        step(1'b1, 1'b0, 8'h00, 1'b0, "wd_gap2");
        check("wd_next_load", 64'({ser_data, ser_start, ser_reset}), 64'({8'h3C, 1'b1, 1'b1}));
`else
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, "hold_send");
            n++;
        end
        check("hold_busy", 64'({busy, ser_reset, ser_data}), 64'({1'b1, 1'b0, 8'h5A}));
        check("hold_no_timeout", 64'(timeout_err), 64'd0);
        check("hold_not_counted", 64'(bytes_sent), 64'd0);
`endif

        // randomized traffic, including done pulses in every state and rare resets
        step(1'b0, 1'b0, 8'h00, 1'b0, "rand_rst");
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 2) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
